// File: rtl/mcpu_ctrl_pkg.sv
// mcpu_ctrl_pkg: shared state, opcode, ALUOP and mux-select encodings for the multicycle MIPS control path.
//   Also provides the control-word struct and the DECODE dispatch function.
package mcpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_SUB   = 3'b111;
    localparam logic [2:0] ALUOP_AND   = 3'b101;
    localparam logic [2:0] ALUOP_OR    = 3'b110;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Unsupported opcodes fall back to FETCH; the output decoder uses that to flag Illegal.
    function automatic state_t decode_next(input logic [5:0] op);
        return (op == OP_LW || op == OP_SW)                      ? S_MEMADR :
               (op == OP_R)                                      ? S_EXEC   :
               (op == OP_BEQ)                                    ? S_BRANCH :
               (op == OP_J)                                      ? S_JUMP   :
               (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)  ? S_IEXEC  :
                                                                   S_FETCH;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_outdec.sv
// mcpu_ctrl_outdec: combinational Moore decode of the control state into datapath controls.
//   state  : current FSM state
//   opcode : IR[31:26], used in DECODE (legality) and IEXEC (ALU op)
//   zero   : ALU zero flag, drives PCWrite in BRANCH
//   ctrl   : full control word
module mcpu_ctrl_outdec
    import mcpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = decode_next(opcode) == S_FETCH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_write   = zero;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode == OP_ANDI) ? ALUOP_AND :
                                 (opcode == OP_ORI)  ? ALUOP_OR  : ALUOP_ADD;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control sequencer for the multicycle MIPS datapath.
//   clk, reset        : clock and synchronous active-high reset
//   Opcode, Zero      : instruction opcode and ALU zero flag
//   PCWrite..PCSource : datapath enables and mux selects
//   State             : current state (debug)
//   InstrDone/Illegal : per-instruction completion and bad-opcode pulses
//   RetireCnt         : wrapping count of retired instructions
module multicycle_control_fsm
    import mcpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOP,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             InstrDone,
    output logic             Illegal,
    output logic [CNT_W-1:0] RetireCnt
);

    state_t           state, state_nxt;
    ctrl_t            dec, ctrl;
    logic [CNT_W-1:0] cnt;

    mcpu_ctrl_outdec u_outdec (
        .state  (state),
        .opcode (Opcode),
        .zero   (Zero),
        .ctrl   (dec)
    );

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = decode_next(Opcode);
            S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXEC:   state_nxt = S_RWB;
            S_IEXEC:  state_nxt = S_IWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (dec.instr_done)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Reset silences every control so a half-finished instruction cannot write anything.
    assign ctrl      = reset ? '0 : dec;
    assign RetireCnt = reset ? '0 : cnt;
    assign State     = state;

    assign PCWrite   = ctrl.pc_write;
    assign IorD      = ctrl.iord;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign RegDst    = ctrl.reg_dst;
    assign RegWrite  = ctrl.reg_write;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOP     = ctrl.alu_op;
    assign PCSource  = ctrl.pc_source;
    assign InstrDone = ctrl.instr_done;
    assign Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed self-checking bench for multicycle_control_fsm (CNT_W=4).
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOP;
    logic [3:0] State;
    logic       InstrDone, Illegal;
    logic [3:0] RetireCnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    multicycle_control_fsm #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .PCSource(PCSource),
        .State(State), .InstrDone(InstrDone), .Illegal(Illegal), .RetireCnt(RetireCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_ctrl();
        return 32'({PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOP, PCSource, InstrDone, Illegal, RetireCnt});
    endfunction

    initial begin
        logic [5:0] iops [3];
        logic [2:0] iexp [3];
        iops = '{6'b001000, 6'b001100, 6'b001101};
        iexp = '{3'b100, 3'b101, 3'b110};
        reset = 1'b1; Opcode = 6'b000000; Zero = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_ctrl", all_ctrl(), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(State), 32'd0);
        chk("rel_cnt", 32'(RetireCnt), 32'd0);
        chk("fetch_ctl", 32'({MemRead, IRWrite, PCWrite, ALUOP}), 32'b111_100);

        // lw: 0,1,2,3,4,0
        Opcode = 6'b100011;
        tick(); chk("lw_s1", 32'(State), 32'd1);
        chk("lw_dec_srcb", 32'(ALUSrcB), 32'd3);
        tick(); chk("lw_s2", 32'(State), 32'd2);
        chk("lw_adr", 32'({ALUSrcA, ALUSrcB, ALUOP}), 32'b1_10_100);
        tick(); chk("lw_s3", 32'(State), 32'd3);
        chk("lw_memrd", 32'({IorD, MemRead, RegWrite}), 32'b110);
        tick(); chk("lw_s4", 32'(State), 32'd4);
        chk("lw_memwb", 32'({RegWrite, MemtoReg, InstrDone}), 32'b111);
        exp_cnt++;
        tick(); chk("lw_s0", 32'(State), 32'd0);
        chk("lw_cnt", 32'(RetireCnt), 32'(exp_cnt % 16));
        chk("lw_done_off", 32'(InstrDone), 32'd0);

        // beq taken then not taken, Zero toggled inside BRANCH too
        Opcode = 6'b000100; Zero = 1'b1;
        tick(); tick();
        chk("beq_s8", 32'(State), 32'd8);
        chk("beq_t", 32'({ALUOP, PCSource, PCWrite, InstrDone}), 32'b111_01_1_1);
        Zero = 1'b0; #1;
        chk("beq_zcomb", 32'(PCWrite), 32'd0);
        exp_cnt++;
        tick(); chk("beq_cnt1", 32'(RetireCnt), 32'(exp_cnt % 16));
        tick(); tick();
        chk("beq_nt", 32'({State, ALUOP, PCSource, PCWrite, InstrDone}), 32'b1000_111_01_0_1);
        exp_cnt++;
        tick(); chk("beq_cnt2", 32'(RetireCnt), 32'(exp_cnt % 16));

        // immediates
        for (int i = 0; i < 3; i++) begin
            Opcode = iops[i];
            tick(); tick();
            chk("imm_iexec", 32'({State, ALUSrcA, ALUSrcB, ALUOP}), 32'({4'd10, 1'b1, 2'b10, iexp[i]}));
            tick();
            chk("imm_iwb", 32'({State, RegWrite, RegDst, MemtoReg, InstrDone}), 32'({4'd11, 4'b1001}));
            exp_cnt++;
            tick(); chk("imm_cnt", 32'(RetireCnt), 32'(exp_cnt % 16));
        end

        // R-type
        Opcode = 6'b000000;
        tick(); tick();
        chk("r_exec", 32'({State, ALUSrcA, ALUSrcB, ALUOP}), 32'({4'd6, 1'b1, 2'b00, 3'b010}));
        tick();
        chk("r_rwb", 32'({State, RegWrite, RegDst, MemtoReg, InstrDone}), 32'({4'd7, 4'b1101}));
        exp_cnt++;
        tick(); chk("r_cnt", 32'(RetireCnt), 32'(exp_cnt % 16));

        // jump
        Opcode = 6'b000010;
        tick(); tick();
        chk("j_s9", 32'({State, PCWrite, PCSource, InstrDone}), 32'({4'd9, 1'b1, 2'b10, 1'b1}));
        exp_cnt++;
        tick(); chk("j_cnt", 32'({State, RetireCnt}), 32'({4'd0, 4'(exp_cnt % 16)}));

        // sw
        Opcode = 6'b101011;
        tick(); tick(); tick();
        chk("sw_s5", 32'({State, MemWrite, IorD, MemRead, InstrDone}), 32'({4'd5, 4'b1101}));
        exp_cnt++;
        tick(); chk("sw_cnt", 32'(RetireCnt), 32'(exp_cnt % 16));

        // illegal
        Opcode = 6'b111111;
        tick();
        chk("ill_dec", 32'({State, Illegal, InstrDone}), 32'({4'd1, 2'b10}));
        tick();
        chk("ill_back", 32'({State, Illegal, InstrDone}), 32'({4'd0, 2'b00}));
        chk("ill_cnt", 32'(RetireCnt), 32'(exp_cnt % 16));

        // reset during MEMRD of a lw
        Opcode = 6'b100011;
        tick(); tick(); tick();
        chk("mid_s3", 32'(State), 32'd3);
        reset = 1'b1; #1;
        chk("mid_ctrl", all_ctrl(), 32'd0);
        tick();
        chk("mid_s0", 32'(State), 32'd0);
        chk("mid_ctrl2", all_ctrl(), 32'd0);
        reset = 1'b0; #1;
        exp_cnt = 0;
        chk("mid_cnt", 32'(RetireCnt), 32'd0);
        chk("mid_regw", 32'(RegWrite), 32'd0);

        // 16 sw: counter wraps 15 -> 0
        Opcode = 6'b101011;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); tick(); tick();
            exp_cnt++;
            chk("wrap_cnt", 32'({State, RetireCnt}), 32'({4'd0, 4'(exp_cnt % 16)}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control sequencer for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. From the instruction opcode and the ALU Zero flag it drives every datapath enable and mux select, and it supplies the 3-bit ALUOP consumed by the ALU control unit. It also keeps a retired-instruction counter for debug and verification.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Opcode  input  6  IR[31:26]; valid from DECODE onward
Zero  input  1  ALU zero flag, sampled only in BRANCH
PCWrite  output  1  PC load enable (unconditional OR beq-taken)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
ALUOP  output  3  ALU operation class (codes below)
PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
State  output  4  current state, for debug
InstrDone  output  1  one-cycle pulse in the final state of each instruction
Illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode
RetireCnt  output  CNT_W  count of InstrDone pulses; wraps

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101.
- ALUOP codes: 100 add (lw, sw, addi, PC+4, branch target); 111 subtract (beq); 101 and (andi); 110 or (ori); 010 funct-decoded (R-type).
- State register:
  - Updated only on the rising edge of clk.
  - reset=1 forces next state FETCH and RetireCnt to 0. This overrides everything else, including in mid-instruction.
  - While reset=1, all outputs except State are forced to 0.
- Outputs are a Moore decode of the state. The one exception is PCWrite in BRANCH, which equals Zero combinationally.
- Unlisted controls are 0. "X" means don't-care, which is driven as 0.
- States, outputs and transitions:
  - FETCH(0): MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=100, PCSource=00 -> DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOP=100. Next state by opcode:
    - lw or sw -> MEMADR.
    - R -> EXEC.
    - beq -> BRANCH.
    - j -> JUMP.
    - addi, andi or ori -> IEXEC.
    - Any other opcode -> FETCH, with Illegal=1 for this cycle. An illegal opcode does not pulse InstrDone and does not count.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOP=100 -> MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MemRead, IorD=1 -> MEMWB.
  - MEMWB(4): RegWrite, MemtoReg=1, RegDst=0, InstrDone -> FETCH.
  - MEMWR(5): MemWrite, IorD=1, InstrDone -> FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOP=010 -> RWB.
  - RWB(7): RegWrite, RegDst=1, MemtoReg=0, InstrDone -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOP=111, PCSource=01, PCWrite=Zero, InstrDone -> FETCH.
  - JUMP(9): PCWrite, PCSource=10, InstrDone -> FETCH.
  - IEXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOP is 100 for addi, 101 for andi, 110 for ori -> IWB.
  - IWB(11): RegWrite, RegDst=0, MemtoReg=0, InstrDone -> FETCH.
  - Encodings 12 to 15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Opcode is used in DECODE, MEMADR and IEXEC. The IR is stable in those states because IRWrite is asserted only in FETCH.
- Latency in cycles, including FETCH:
  - lw 5.
  - sw, R-type, addi, andi, ori 4.
  - beq, j 3.
  - Illegal opcode 2.
- RetireCnt increments by 1 on each clock edge where InstrDone=1. It wraps from all-ones to 0.

Decomposition:
- Package mcpu_ctrl_pkg holds:
  - the state enumeration (4-bit);
  - the opcode constants;
  - the ALUOP codes;
  - the ALUSrcB and PCSource select encodings.
- The ALU control unit uses the same ALUOP constants from this package.
- One combinational sub-module, mcpu_ctrl_outdec, maps (state, Opcode, Zero) to the control outputs. The FSM, the counter and the reset gating stay in the top module.

Test Plan:
- Reset: hold reset=1 for 3 cycles, then release -> all controls 0 during reset; State=0 and RetireCnt=0 after release. The first post-reset cycle has MemRead=IRWrite=PCWrite=1 and ALUOP=100.
- lw: Opcode=100011 -> State sequence 0,1,2,3,4,0. MEMRD has IorD=1 and MemRead=1. MEMWB has RegWrite=1 and MemtoReg=1. InstrDone pulses once and RetireCnt=1.
- beq: Opcode=000100, first with Zero=1, then with Zero=0 -> States 0,1,8. In state 8, ALUOP=111, PCSource=01, and PCWrite=1 then 0 respectively. InstrDone pulses in both cases.
- Immediates: addi, andi, ori -> ALUOP in IEXEC is 100, 101, 110 respectively. IWB has RegWrite=1 and RegDst=0. R-type -> ALUOP=010 in EXEC and RegDst=1 in RWB.
- Illegal opcode 111111 -> States 0,1,0. Illegal=1 for exactly one cycle, InstrDone=0, and RetireCnt unchanged.
- Reset mid-instruction: assert reset in MEMRD of a lw -> State=0 on the next edge, no RegWrite is ever seen, and RetireCnt=0. With CNT_W=4, execute 16 sw instructions -> RetireCnt wraps from 15 to 0.
